// File: rtl/firebird_mc_ctrl.sv
// Multi-cycle main controller for the Firebird RV32I core: sequences the shared
// datapath through FETCH/DECODE/EXEC/MEM/WB and stalls on the memory handshake.
module firebird_mc_ctrl #(
    parameter int INST_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              alu_zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_sel_inst,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              aluout_we,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              illegal,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;
    logic       is_beq;
    logic       is_bne;
    logic       is_branch;
    logic       is_ralu;
    logic       is_ialu;
    logic       is_legal;
    logic       unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign unused_inst = ^{inst[INST_W-1:15], inst[11:7]};

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_bne    = (opcode == OP_BRANCH) && (funct3 == 3'b001);
    assign is_branch = is_beq || is_bne;
    assign is_ralu   = (opcode == OP_RALU);
    assign is_ialu   = (opcode == OP_IALU);
    assign is_legal  = is_load || is_store || is_branch || is_ralu || is_ialu;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_inst = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        aluout_we    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_sel_inst = 1'b1;
                alu_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target = old PC + imm, parked in the ALU-out register.
                alu_src_b = 2'b10;
                aluout_we = 1'b1;
                state_d   = is_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (is_load || is_store) begin
                    alu_src_b = 2'b10;
                    aluout_we = 1'b1;
                    state_d   = S_MEM;
                end else if (is_ralu) begin
                    alu_op    = 2'b10;
                    aluout_we = 1'b1;
                    state_d   = S_WB;
                end else if (is_ialu) begin
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                    aluout_we = 1'b1;
                    state_d   = S_WB;
                end else if (is_branch) begin
                    alu_op  = 2'b01;
                    pc_src  = 1'b1;
                    pc_we   = (is_beq && alu_zero) || (is_bne && !alu_zero);
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    retire  = is_store;
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_load;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Reset overrides the decode in the same cycle so no strobe escapes.
        if (rst) begin
            state_d      = S_FETCH;
            retire       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_sel_inst = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'b00;
            alu_op       = 2'b00;
            aluout_we    = 1'b0;
            rf_we        = 1'b0;
            wb_sel       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_q == S_DECODE && !is_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign state   = rst ? S_FETCH : state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_firebird_mc_ctrl.sv
// Scoreboard bench for firebird_mc_ctrl: each driven cycle queues its expected
// control vector and retired count; a negedge monitor pops and compares.
module tb_firebird_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_inst;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        aluout_we;
    logic        rf_we;
    logic        wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    firebird_mc_ctrl #(
        .INST_W(32),
        .CNT_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_sel_inst(mem_sel_inst),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .aluout_we   (aluout_we),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .state       (state),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = '0;
    logic        exp_ill  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Field order: state, mem_req, mem_we, mem_sel_inst, ir_we, pc_we, pc_src,
    // alu_src_a, alu_src_b, alu_op, aluout_we, rf_we, wb_sel, illegal.
    function automatic logic [17:0] mk(input logic [2:0] st, input logic req, input logic we,
                                       input logic sel, input logic irw, input logic pcw,
                                       input logic pcs, input logic a, input logic [1:0] b,
                                       input logic [1:0] op, input logic aw, input logic rfw,
                                       input logic wbs);
        return {st, req, we, sel, irw, pcw, pcs, a, b, op, aw, rfw, wbs, exp_ill};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_ctl"},
                     32'({state, mem_req, mem_we, mem_sel_inst, ir_we, pc_we, pc_src,
                          alu_src_a, alu_src_b, alu_op, aluout_we, rf_we, wb_sel, illegal}),
                     32'(e.ctl));
            check_eq({e.tag, "_cnt"}, instret, e.cnt);
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cycle(input logic rdy, input logic z, input logic [17:0] ctl,
                         input string tag, input logic ret);
        exp_t e;
        mem_ready = rdy;
        alu_zero  = z;
        e.tag = tag;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (ret) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic rst_cycle(input string tag);
        rst = 1'b1;
        cycle(rnd(), rnd(), mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), tag, 0);
        exp_cnt = '0;
        exp_ill = 1'b0;
        rst     = 1'b0;
    endtask

    // rst_at_mem >= 0 asserts reset in that MEM cycle instead of continuing.
    task automatic run_instr(input logic [31:0] ins, input int unsigned fw, input int unsigned mw,
                             input logic z, input int rst_at_mem);
        logic [6:0] op;
        logic [2:0] f3;
        logic ld, st, br, ra, ia, taken;
        inst = ins;
        op = ins[6:0];
        f3 = ins[14:12];
        ld = (op == 7'b0000011);
        st = (op == 7'b0100011);
        br = (op == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
        ra = (op == 7'b0110011);
        ia = (op == 7'b0010011);

        for (int unsigned k = 0; k < fw; k++)
            cycle(1'b0, z, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0), "fetch_wait", 0);
        cycle(1'b1, z, mk(3'd0, 1, 0, 1, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0), "fetch", 0);
        cycle(rnd(), z, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 0, 0), "decode", 0);

        if (!(ld || st || br || ra || ia)) begin
            exp_ill = 1'b1;
            for (int unsigned k = 0; k < 20; k++)
                cycle(rnd(), rnd(), mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), "halt", 0);
            return;
        end

        if (br) begin
            taken = (f3 == 3'b000) ? z : !z;
            cycle(rnd(), z, mk(3'd2, 0, 0, 0, 0, taken, 1, 1, 2'b00, 2'b01, 0, 0, 0), "exec_br", 1);
            return;
        end
        if (ld || st)
            cycle(rnd(), z, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1, 0, 0), "exec_mem", 0);
        else if (ra)
            cycle(rnd(), z, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 1, 0, 0), "exec_r", 0);
        else
            cycle(rnd(), z, mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 1, 0, 0), "exec_i", 0);

        if (ld || st) begin
            for (int k = 0; k < int'(mw); k++) begin
                if (k == rst_at_mem) begin
                    rst_cycle("rst_in_mem");
                    return;
                end
                cycle(1'b0, z, mk(3'd3, 1, st, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), "mem_wait", 0);
            end
            cycle(1'b1, z, mk(3'd3, 1, st, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0), "mem", st);
        end
        if (!st)
            cycle(rnd(), z, mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, ld), "wb", 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        inst      = 32'h0000_0013;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_cycle("reset0");
        rst_cycle("reset1");

        run_instr(32'h0050_0093, 0, 0, 1'b0, -1);  // ADDI x1,x0,5
        run_instr(32'h0000_a103, 3, 2, 1'b0, -1);  // LW with waits
        run_instr(32'h0020_8463, 0, 0, 1'b1, -1);  // BEQ taken
        run_instr(32'h0020_9463, 0, 0, 1'b1, -1);  // BNE not taken
        run_instr(32'h0020_a023, 0, 0, 1'b0, -1);  // SW
        run_instr(32'h0020_a023, 2, 3, 1'b0, -1);  // SW with waits
        run_instr(32'h0020_81b3, 1, 0, 1'b0, -1);  // ADD
        run_instr(32'h0020_9463, 0, 0, 1'b0, -1);  // BNE taken
        run_instr(32'h0020_8463, 0, 0, 1'b0, -1);  // BEQ not taken
        run_instr(32'h0000_a103, 0, 0, 1'b1, -1);  // LW zero-wait

        run_instr(32'h0000_007f, 0, 0, 1'b0, -1);  // unsupported opcode
        rst_cycle("reset_halt");
        run_instr(32'h0050_0093, 0, 0, 1'b0, -1);

        run_instr(32'h0020_c463, 0, 0, 1'b0, -1);  // branch funct3 100
        rst_cycle("reset_halt2");

        run_instr(32'h0050_0093, 0, 0, 1'b0, -1);
        run_instr(32'h0020_a023, 0, 5, 1'b0, 2);   // reset during pending store
        run_instr(32'h0050_0093, 2, 0, 1'b0, -1);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/firebird_mc_ctrl.md
# firebird_mc_ctrl

Multi-cycle main controller for the Firebird RV32I core. It sequences one shared datapath (PC, IR, register file, ALU, immediate generator, unified memory port) through FETCH/DECODE/EXEC/MEM/WB states. It drives all datapath strobes and mux selects and stalls on a memory ready handshake. It is the control half of the multi-cycle core. The existing immediate generator stays combinational and is fed from the IR this block loads.

## Interface
- `INST_W`, 32: instruction width.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `inst` in INST_W: IR contents; valid from DECODE onward.
- `alu_zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory accepted/completed the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `mem_sel_inst` out 1: 1 = address from PC, 0 = address from ALU-out register.
- `ir_we` out 1: load IR and old-PC register from the memory read data.
- `pc_we` out 1: PC write enable.
- `pc_src` out 1: 0 = ALU result (PC+4), 1 = ALU-out register (branch target).
- `alu_src_a` out 1: 0 = old PC, 1 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = constant 4, 10 = imm.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode funct3/funct7.
- `aluout_we` out 1: latch ALU result into the ALU-out register.
- `rf_we` out 1: register-file write.
- `wb_sel` out 1: 0 = ALU-out, 1 = memory data register.
- `illegal` out 1: sticky; opcode unsupported.
- `state` out 3: current state, for debug.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Supported opcodes: 0000011 load, 0100011 store, 1100011 branch (funct3 000 BEQ, 001 BNE), 0110011 R-ALU, 0010011 I-ALU.
- Every other opcode, and branch funct3 not 000/001, is illegal.
- FETCH:
  - Drive mem_req=1, mem_sel_inst=1, alu_src_a=0 (PC), alu_src_b=01, alu_op=00.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: assert ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE:
  - Drive alu_src_a=0 (old PC), alu_src_b=10, alu_op=00, aluout_we=1 to precompute the branch target.
  - Illegal opcode: go to HALT and set `illegal`. Otherwise go to EXEC.
- EXEC, load/store: alu_src_a=1, alu_src_b=10, alu_op=00, aluout_we=1, then go to MEM.
- EXEC, R-ALU: alu_src_a=1, alu_src_b=00, alu_op=10, aluout_we=1, then go to WB.
- EXEC, I-ALU: alu_src_a=1, alu_src_b=10, alu_op=10, aluout_we=1, then go to WB.
- EXEC, branch:
  - Drive alu_src_a=1, alu_src_b=00, alu_op=01, aluout_we=0.
  - pc_we = (BEQ & alu_zero) | (BNE & ~alu_zero), with pc_src=1.
  - Go to FETCH. The instruction retires.
- MEM:
  - Drive mem_req=1, mem_sel_inst=0, mem_we = store.
  - Stay in MEM while mem_ready=0.
  - On mem_ready: a load goes to WB; a store retires and goes to FETCH.
- WB: rf_we=1, wb_sel = load, then go to FETCH. The instruction retires.
- HALT: absorbing; all strobes 0. Only `rst` exits HALT.
- `instret` increments by 1 (wrapping modulo 2^CNT_W) in the cycle an instruction retires:
  - EXEC for a branch;
  - MEM on mem_ready for a store;
  - WB for everything else.
- All strobes not listed for a state are 0. All selects not listed are 00/0.

## Timing
- Outputs are Moore-decoded from `state` and `inst`. The only combinational inputs to outputs are mem_ready (ir_we, pc_we in FETCH) and alu_zero (pc_we in EXEC).
- Reset, in the cycle rst=1:
  - state←FETCH, instret←0, illegal←0.
  - Every strobe output is gated to 0 (mem_req, mem_we, ir_we, pc_we, aluout_we, rf_we).
  - Selects and `state` read 0.
- First cycle after rst falls: FETCH with mem_req=1.
- Reset mid-operation (any state, including MEM with a pending request): rst wins. mem_req drops in that same cycle and no rf_we or pc_we is issued.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - branch 3 cycles;
  - store and R/I-ALU 4 cycles;
  - load 5 cycles.
- Each wait cycle on mem_ready adds one cycle to the state that is waiting.
- mem_req stays continuously high from the first request cycle until the cycle mem_ready=1 inclusive. Address and mem_we are stable throughout.
- ir_we, pc_we and rf_we are single-cycle pulses, at most one each per instruction.

## Test plan
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → state sequence 0,1,2,4,0; rf_we high exactly in cycle 4; instret 0→1.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEM → mem_req high for 4 and 3 consecutive cycles; load takes 10 cycles total; wb_sel=1 in WB.
- BEQ with alu_zero=1, then BNE with alu_zero=1 → first: pc_we=1, pc_src=1 in EXEC; second: pc_we=0; each takes 3 cycles; instret +2.
- SW (opcode 0100011) → mem_we=1 only in MEM; no rf_we; back to FETCH after mem_ready; instret +1.
- Opcode 1111111 → DECODE→HALT; illegal=1 and held; no strobes for 20 cycles; rst pulse → FETCH, illegal=0, instret=0.
- rst asserted in MEM during a store with mem_ready=0 → next cycle mem_req=0, mem_we=0, state=0; instret unchanged until reset clears it to 0.
